// File: rtl/conv_sched_pkg.sv
`default_nettype none
// ============================================================================
// conv_sched_pkg : state encoding and sizing helpers for conv_batch_scheduler
// Revision 1.0
// ============================================================================
package conv_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WLOAD     = 3'd1,
    S_WWAIT     = 3'd2,
    S_SCAN_KICK = 3'd3,
    S_SCAN_WAIT = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_batch_scheduler_wbank_tracker.sv
`default_nettype none
// ============================================================================
// wbank_tracker : per-bank weight-valid flags and the prefetch pending flag
// Optional: CONV_BATCH_SCHED_OVERLAP_EN enables pending_valid. Revision 1.0
// ============================================================================
module wbank_tracker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       active,
  input  logic       wload_done,
  input  logic       load_bank,
  input  logic       release_en,
  input  logic       release_bank,
  input  logic       scan_kick,
  input  logic       prefetch_window,
  output logic [1:0] bank_valid,
  output logic       pending_valid
);

  // A completion and a release never target the same bank in one cycle; set wins.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      bank_valid <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (active && wload_done && (load_bank == 1'(b))) begin
          bank_valid[b] <= 1'b1;
        end else if (release_en && (release_bank == 1'(b))) begin
          bank_valid[b] <= 1'b0;
        end
      end
    end
  end

`ifdef CONV_BATCH_SCHED_OVERLAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      pending_valid <= 1'b0;
    end else if (active && prefetch_window && wload_done) begin
      pending_valid <= 1'b1;
    end else if (scan_kick) begin
      pending_valid <= 1'b0;
    end
  end
`else
  logic unused_prefetch;
  assign unused_prefetch = scan_kick ^ prefetch_window;
  assign pending_valid   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/conv_batch_scheduler.sv
`default_nettype none
// ============================================================================
// conv_batch_scheduler : splits a layer into UNIT_NUM-channel batches and
// sequences weight loads and scans. Optional: CONV_BATCH_SCHED_OVERLAP_EN.
// Revision 1.0
// ============================================================================
module conv_batch_scheduler
  import conv_sched_pkg::*;
#(
  parameter  int COUT        = 32,
  parameter  int UNIT_NUM    = 16,
  localparam int NUM_BATCHES = ceil_div(COUT, UNIT_NUM),
  localparam int BW          = idx_width(NUM_BATCHES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          layer_start,
  input  logic          abort,
  output logic          wload_req,
  output logic [BW-1:0] wload_batch,
  output logic          wload_bank,
  input  logic          wload_done,
  output logic          scan_start,
  input  logic          scan_done,
  output logic          compute_bank,
  output logic [BW-1:0] batch_idx,
  output logic          busy,
  output logic          layer_done
);

  localparam logic [BW-1:0] LAST_BATCH = BW'(NUM_BATCHES - 1);

  state_t        state, state_n;
  logic [BW-1:0] batch, batch_n;
  logic          bank, bank_n;

  logic          wload_req_n, wload_bank_n, scan_start_n, compute_bank_n;
  logic          busy_n, layer_done_n;
  logic [BW-1:0] wload_batch_n, batch_idx_n;

  logic [1:0]    bank_valid;
  logic          pending_valid;
  logic          last_batch, loaded;
  logic          track_active, prefetch_window, release_en;

  assign last_batch      = (batch == LAST_BATCH);
  assign loaded          = wload_done || bank_valid[bank];
  assign track_active    = (state != S_IDLE) && !abort;
  assign prefetch_window = (state == S_SCAN_KICK) || (state == S_SCAN_WAIT);
  assign release_en      = (state == S_SCAN_WAIT) && scan_done;

`ifndef CONV_BATCH_SCHED_OVERLAP_EN
  logic unused_pending;
  assign unused_pending = pending_valid;
`endif

  wbank_tracker u_wbank_tracker (
    .clk             (clk),
    .rst_n           (rst_n),
    .abort           (abort),
    .active          (track_active),
    .wload_done      (wload_done),
    .load_bank       (wload_bank),
    .release_en      (release_en),
    .release_bank    (compute_bank),
    .scan_kick       (scan_start),
    .prefetch_window (prefetch_window),
    .bank_valid      (bank_valid),
    .pending_valid   (pending_valid)
  );

  always_comb begin
    state_n        = state;
    batch_n        = batch;
    bank_n         = bank;
    wload_req_n    = 1'b0;
    wload_batch_n  = wload_batch;
    wload_bank_n   = wload_bank;
    scan_start_n   = 1'b0;
    compute_bank_n = compute_bank;
    batch_idx_n    = batch_idx;
    layer_done_n   = 1'b0;
    busy_n         = 1'b0;

    case (state)
      S_IDLE: begin
        if (layer_start) begin
          state_n = S_WLOAD;
          batch_n = '0;
          bank_n  = 1'b0;
        end
      end
      S_WLOAD:     state_n = S_WWAIT;
      S_WWAIT: begin
        if (loaded) state_n = S_SCAN_KICK;
      end
      S_SCAN_KICK: state_n = S_SCAN_WAIT;
      S_SCAN_WAIT: begin
        if (scan_done) begin
          if (last_batch) begin
            state_n = S_FINISH;
          end else begin
            batch_n = batch + BW'(1);
            bank_n  = ~bank;
`ifdef CONV_BATCH_SCHED_OVERLAP_EN
            // A prefetch finishing with the scan counts as already loaded.
            state_n = (pending_valid || wload_done) ? S_SCAN_KICK : S_WWAIT;
`else
            state_n = S_WLOAD;
`endif
          end
        end
      end
      S_FINISH:    state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase

    if (abort) begin
      state_n = S_IDLE;
      batch_n = batch;
      bank_n  = bank;
    end

    // Outputs are registered, so each pulse is raised on entry to its state.
    if (state_n == S_WLOAD) begin
      wload_req_n   = 1'b1;
      wload_batch_n = batch_n;
      wload_bank_n  = bank_n;
    end

    if (state_n == S_SCAN_KICK) begin
      scan_start_n   = 1'b1;
      compute_bank_n = bank_n;
      batch_idx_n    = batch_n;
`ifdef CONV_BATCH_SCHED_OVERLAP_EN
      if (batch_n != LAST_BATCH) begin
        wload_req_n   = 1'b1;
        wload_batch_n = batch_n + BW'(1);
        wload_bank_n  = ~bank_n;
      end
`endif
    end

    layer_done_n = (state == S_FINISH) && !abort;
    busy_n       = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      batch        <= '0;
      bank         <= 1'b0;
      wload_req    <= 1'b0;
      wload_batch  <= '0;
      wload_bank   <= 1'b0;
      scan_start   <= 1'b0;
      compute_bank <= 1'b0;
      batch_idx    <= '0;
      busy         <= 1'b0;
      layer_done   <= 1'b0;
    end else begin
      state        <= state_n;
      batch        <= batch_n;
      bank         <= bank_n;
      wload_req    <= wload_req_n;
      wload_batch  <= wload_batch_n;
      wload_bank   <= wload_bank_n;
      scan_start   <= scan_start_n;
      compute_bank <= compute_bank_n;
      batch_idx    <= batch_idx_n;
      busy         <= busy_n;
      layer_done   <= layer_done_n;
    end
  end

endmodule
`default_nettype wire
